// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the front-panel button controller.
package btn_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_kind_e;

  localparam int KIND_W = 2;

  // Width of a button index; a single button still gets one bit.
  function automatic int id_w(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchronizer, tick-based debouncer, edge detection and
// the PRESS/RELEASE/REPEAT pending flags. The hold counter for auto-repeat
// exists only when BUTTON_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  input  logic take_press,
  input  logic take_rel,
  input  logic take_rep,
  output logic clean,
  output logic press_pend,
  output logic rel_pend,
  output logic rep_pend,
  output logic drop
);

  localparam int SW = cnt_w(STABLE_TICKS - 1);

  logic          sync1, sync2, clean_d;
  logic [SW-1:0] stab_cnt;
  logic          rise, fall, set_rep;

  // Two-flop synchronizer for the asynchronous raw level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: flip clean only after STABLE_TICKS consecutive differing ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean    <= 1'b0;
      stab_cnt <= '0;
    end else if (sync2 == clean) begin
      stab_cnt <= '0;
    end else if (tick) begin
      if (stab_cnt == SW'(STABLE_TICKS - 1)) begin
        clean    <= sync2;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + SW'(1);
      end
    end
  end

  // Delayed copy of clean for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clean_d <= 1'b0;
    else        clean_d <= clean;
  end

  assign rise = clean & ~clean_d;
  assign fall = ~clean & clean_d;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int HW = cnt_w(REPEAT_DELAY);
  logic [HW-1:0] hold_cnt;

  // The tick that would bring the count to REPEAT_DELAY raises a repeat
  assign set_rep = clean & tick & (hold_cnt == HW'(REPEAT_DELAY - 1));

  // Hold counter: ticks while clean is high, reloads after each repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!clean) begin
      hold_cnt <= '0;
    end else if (tick) begin
      if (set_rep)              hold_cnt <= HW'(REPEAT_DELAY - REPEAT_RATE);
      else if (hold_cnt != '1)  hold_cnt <= hold_cnt + HW'(1);
    end
  end
`else
  // No hold counter; the repeat parameters only qualify a constant-zero source
  localparam bit REP_CFG_OK = (REPEAT_RATE <= REPEAT_DELAY);
  assign set_rep = 1'b0 & REP_CFG_OK;
`endif

  // A set arriving on an already-pending, unconsumed flag is lost
  assign drop = (rise    & press_pend & ~take_press) |
                (fall    & rel_pend   & ~take_rel)   |
                (set_rep & rep_pend   & ~take_rep);

  // Pending flags: set wins over a same-cycle take; release cancels repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend <= 1'b0;
      rel_pend   <= 1'b0;
      rep_pend   <= 1'b0;
    end else begin
      press_pend <= rise    | (press_pend & ~take_press);
      rel_pend   <= fall    | (rel_pend   & ~take_rel);
      rep_pend   <= set_rep | (rep_pend   & ~take_rep & ~fall);
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Front-panel input controller: shared prescaler tick, N_BTN debounced
// channels, round-robin arbitration onto one valid/ready event port.
// Optional auto-repeat events are built when BUTTON_AUTOREPEAT_EN is defined.
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 16,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  localparam int ID_W        = id_w(N_BTN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_raw,
  output logic [N_BTN-1:0]  btn_clean,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [KIND_W-1:0] evt_kind,
  output logic              evt_overflow
);

  logic [TICK_DIV-1:0] presc;
  logic                tick;
  logic [N_BTN-1:0]    press_p, rel_p, rep_p, elig, drop;
  logic [N_BTN-1:0]    take_press, take_rel, take_rep;
  logic [ID_W-1:0]     rr_ptr, sel;
  logic                found, load;
  evt_kind_e           sel_kind;

  // Free-running prescaler; tick on the all-ones count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + TICK_DIV'(1);
  end

  assign tick = &presc;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .raw        (btn_raw[g]),
      .take_press (take_press[g]),
      .take_rel   (take_rel[g]),
      .take_rep   (take_rep[g]),
      .clean      (btn_clean[g]),
      .press_pend (press_p[g]),
      .rel_pend   (rel_p[g]),
      .rep_pend   (rep_p[g]),
      .drop       (drop[g])
    );
  end

  assign elig = press_p | rel_p | rep_p;

  // Round-robin pick: first eligible index at or after the pointer, wrapping
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // Within one button: press before repeat before release
  always_comb begin
    sel_kind = EVT_RELEASE;
    if (press_p[sel])    sel_kind = EVT_PRESS;
    else if (rep_p[sel]) sel_kind = EVT_REPEAT;
  end

  assign load = ~evt_valid & found;

  // Clear exactly the flag being loaded into the output register
  always_comb begin
    take_press = '0;
    take_rel   = '0;
    take_rep   = '0;
    if (load) begin
      take_press[sel] = (sel_kind == EVT_PRESS);
      take_rep[sel]   = (sel_kind == EVT_REPEAT);
      take_rel[sel]   = (sel_kind == EVT_RELEASE);
    end
  end

  // Output register, RR pointer and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_kind     <= '0;
      rr_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_id    <= sel;
        evt_kind  <= sel_kind;
        rr_ptr    <= ID_W'((int'(sel) + 1) % N_BTN);
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (|drop) evt_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Front-panel input controller. Owns N_BTN raw buttons, debounces each on a shared prescaled tick, and turns clean edges into PRESS/RELEASE (optionally REPEAT) events. Simultaneous events from different buttons are queued and arbitrated round-robin onto a single valid/ready event port that feeds the CPU control FSM (step/run/reset/load).

Parameters:
N_BTN, 4, number of buttons (1..8)
TICK_DIV, 16, prescaler width; one tick every 2**TICK_DIV clk cycles
STABLE_TICKS, 4, consecutive differing ticks required before clean flips (>=1)
REPEAT_DELAY, 32, ticks held before first REPEAT
REPEAT_RATE, 8, ticks between subsequent REPEATs

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_raw  in  N_BTN  raw asynchronous button levels, active high
btn_clean  out  N_BTN  debounced levels
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_id  out  max(1,$clog2(N_BTN))  button index of event
evt_kind  out  2  0=PRESS 1=RELEASE 2=REPEAT
evt_overflow  out  1  sticky: an event was dropped

Behaviour:
- Reset (async, rst_n=0): all sync FFs, btn_clean, counters, pending flags, evt_valid, evt_id, evt_kind, evt_overflow = 0; prescaler = 0; round-robin pointer = 0. Reset mid-handshake discards the held event.
- Tick: TICK_DIV-bit free-running counter; tick = 1 for one cycle when counter is all-ones. Wraps naturally.
- Per button: 2-FF synchronizer -> sync. If sync == clean: stable count <= 0. Else on tick: count+1; on the tick where count == STABLE_TICKS-1, clean <= sync and count <= 0. A glitch shorter than STABLE_TICKS ticks never reaches btn_clean.
- Edge -> pending: clean 0->1 sets press_pend; clean 1->0 sets rel_pend, clears rep_pend, and resets the hold counter. Set occurs the cycle after clean changes.
- Overflow: a flag set while already set (not being consumed that cycle) is dropped and evt_overflow <= 1. It is cleared only by reset.
- Arbitration: a button is eligible if any of its flags is set. Within a button the priority is press > repeat > release, so a tap always yields PRESS before RELEASE. Across buttons, the lowest index at or after the RR pointer is chosen, with wrap.
- Output register: when evt_valid=0 and an eligible button exists, load evt_id/evt_kind, set evt_valid, clear that flag, and set pointer <= id+1 (mod N_BTN), all in the same cycle. evt_valid/evt_id/evt_kind hold steady until evt_valid & evt_ready. After the transfer cycle evt_valid=0 for at least one cycle; the next event loads the following cycle.
- Latency: raw edge -> btn_clean is 2 sync cycles + STABLE_TICKS ticks (tick phase dependent). btn_clean edge -> evt_valid is 2 cycles when idle.
- A flag set and consumed in the same cycle for the same button/kind: the set wins (flag stays 1).

Optional Feature:
BUTTON_AUTOREPEAT_EN.
- Defined: per-button hold counter counts ticks while clean=1. On reaching REPEAT_DELAY it sets rep_pend and reloads to REPEAT_DELAY-REPEAT_RATE, so repeats follow every REPEAT_RATE ticks. The counter saturates and never wraps.
- Undefined: no hold counters are built; evt_kind is never 2.

Decomposition:
- Package btn_pkg: evt_kind_e enum (EVT_PRESS, EVT_RELEASE, EVT_REPEAT); localparams ID_W and width helpers for the stable and hold counters.
- Sub-module btn_channel: one per button (synchronizer, stable counter, hold counter, pending flags). The top level keeps the prescaler, RR arbiter and output register.

Test Plan:
Bench params: TICK_DIV=2, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BTN=4.
- Reset values: rst_n low -> all outputs 0. Assert rst_n mid-event with evt_valid=1 -> evt_valid drops asynchronously, pointer returns to 0.
- Glitch: btn_raw[1] high for 2 ticks, then low -> btn_clean stays 0, no event. Held for 3 ticks -> btn_clean[1]=1, then PRESS id=1 two cycles later.
- Tap: btn 2 press then release, with evt_ready=0 until both are pending -> events PRESS id=2, then RELEASE id=2, in that order.
- Fairness: btn 0 and btn 3 both press in the same cycle, evt_ready=1 -> id=0 then id=3. Repeat with pointer=1 -> id=3 then id=0.
- Backpressure/overflow: evt_ready=0, btn 0 taps twice -> evt_overflow=1. evt_id/evt_kind stay stable throughout stall; first PRESS delivered when ready rises.
- Autorepeat (macro on): hold btn 1 for 12 ticks after clean -> PRESS, then REPEAT at ticks 5, 7, 9, 11, then RELEASE. Macro off -> PRESS, RELEASE only.
